// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with a START/BUSY/DONE handshake.
// Base integer ops (opcodes 0-8) finish in one cycle. Multiply/divide
// (opcodes 9-15) run iteratively over SIZE cycles.
// Build option: define ALU_MULDIV_EN to include the iterative mul/div datapath.
// Without it, opcodes 9-15 finish in one cycle with RESULT=0 and BUSY stays 0.
//
// state | meaning
// IDLE  | waiting for START; single-cycle ops complete here
// RUN   | one shift-add / restoring-subtract step per cycle
// FIN   | DONE cycle of a mul/div op; a new START is accepted here

module alu_multicycle #(
    parameter int SIZE = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic [3:0]      OPERATION,
    output logic            BUSY,
    output logic            DONE,
    output logic [SIZE-1:0] RESULT,
    output logic            ZERO
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_LUI   = 4'd7;
    localparam logic [3:0] OP_AUIPC = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_MULH  = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    logic [SIZE-1:0] imm_u;
    logic [SIZE-1:0] alu_res;

    assign imm_u = {B[SIZE-13:0], 12'b0};

    // Single-cycle result; mul/div opcodes yield 0 here (used only when mul/div is absent).
    always_comb begin
        alu_res = '0;
        case (OPERATION)
            OP_ADD:   alu_res = A + B;
            OP_SUB:   alu_res = A - B;
            OP_AND:   alu_res = A & B;
            OP_OR:    alu_res = A | B;
            OP_XOR:   alu_res = A ^ B;
            OP_SLT:   alu_res = {{(SIZE-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  alu_res = {{(SIZE-1){1'b0}}, (A < B)};
            OP_LUI:   alu_res = imm_u;
            OP_AUIPC: alu_res = A + imm_u;
            OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU:
                      alu_res = '0;
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;
    localparam int         CW      = $clog2(SIZE);

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2*SIZE-1:0] acc;     // multiply: {partial product, multiplier}; divide: low half is quotient/dividend
    logic [SIZE-1:0]   opb;     // multiplicand or divisor magnitude
    logic [SIZE:0]     rem;     // divide partial remainder
    logic [3:0]        op_q;
    logic              neg_q;   // final result needs negation

    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [SIZE-1:0]   a_mag;
    logic [SIZE-1:0]   b_mag;
    logic              neg_start;

    logic              is_mul;
    logic [SIZE:0]     mul_sum;
    logic [2*SIZE-1:0] mul_next;
    logic [SIZE:0]     rem_sh;
    logic [SIZE:0]     rem_diff;
    logic [SIZE-1:0]   div_q_next;
    logic [SIZE:0]     div_r_next;
    logic [2*SIZE-1:0] acc_next;
    logic [SIZE:0]     rem_next;
    logic [2*SIZE-1:0] prod_fix;
    logic [SIZE-1:0]   fin_res;

    // Operand magnitudes and result sign for the op being issued.
    always_comb begin
        is_signed = (OPERATION == OP_MULH) || (OPERATION == OP_DIV) || (OPERATION == OP_REM);
        a_neg     = is_signed & A[SIZE-1];
        b_neg     = is_signed & B[SIZE-1];
        a_mag     = a_neg ? (~A + 1'b1) : A;
        b_mag     = b_neg ? (~B + 1'b1) : B;
        neg_start = 1'b0;
        case (OPERATION)
            OP_MULH: neg_start = a_neg ^ b_neg;
            // A zero divisor must keep the all-ones quotient unsigned-looking.
            OP_DIV:  neg_start = (a_neg ^ b_neg) & (B != '0);
            OP_REM:  neg_start = a_neg;
            default: neg_start = 1'b0;
        endcase
    end

    // One iteration step plus the sign-corrected final value from that step.
    always_comb begin
        is_mul     = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
        mul_sum    = {1'b0, acc[2*SIZE-1:SIZE]} + (acc[0] ? {1'b0, opb} : {(SIZE+1){1'b0}});
        mul_next   = {mul_sum, acc[SIZE-1:1]};
        rem_sh     = {rem[SIZE-1:0], acc[SIZE-1]};
        rem_diff   = rem_sh - {1'b0, opb};
        div_q_next = {acc[SIZE-2:0], ~rem_diff[SIZE]};
        div_r_next = rem_diff[SIZE] ? rem_sh : rem_diff;
        acc_next   = is_mul ? mul_next : {acc[2*SIZE-1:SIZE], div_q_next};
        rem_next   = is_mul ? rem : div_r_next;
        prod_fix   = neg_q ? (~mul_next + 1'b1) : mul_next;
        fin_res    = '0;
        case (op_q)
            OP_MUL:          fin_res = mul_next[SIZE-1:0];
            OP_MULH,
            OP_MULHU:        fin_res = prod_fix[2*SIZE-1:SIZE];
            OP_DIV, OP_DIVU: fin_res = neg_q ? (~div_q_next + 1'b1) : div_q_next;
            OP_REM, OP_REMU: fin_res = neg_q ? (~div_r_next[SIZE-1:0] + 1'b1) : div_r_next[SIZE-1:0];
            default:         fin_res = '0;
        endcase
    end

    // Handshake FSM, iteration registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            rem    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
            ZERO   <= 1'b1;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE, ST_FIN: begin
                    state <= ST_IDLE;
                    if (START) begin
                        if (OPERATION >= OP_MUL) begin
                            acc   <= {{SIZE{1'b0}}, a_mag};
                            opb   <= b_mag;
                            rem   <= '0;
                            op_q  <= OPERATION;
                            neg_q <= neg_start;
                            count <= CW'(SIZE - 1);
                            state <= ST_RUN;
                        end else begin
                            RESULT <= alu_res;
                            ZERO   <= (alu_res == '0);
                            DONE   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    if (count == '0) begin
                        RESULT <= fin_res;
                        ZERO   <= (fin_res == '0);
                        DONE   <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY = (state == ST_RUN);

`else

    // Every accepted op completes in one cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            DONE   <= 1'b0;
            RESULT <= '0;
            ZERO   <= 1'b1;
        end else begin
            DONE <= START;
            if (START) begin
                RESULT <= alu_res;
                ZERO   <= (alu_res == '0);
            end
        end
    end

    assign BUSY = 1'b0;

`endif

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the combinational datapath ALU. It executes the base integer operations in one cycle, and the RV32M-style multiply/divide operations iteratively over SIZE cycles. Operands are accepted under a START/BUSY/DONE handshake. The block sits in the execute stage, and the core stalls on BUSY.

## Interface
- SIZE, 32: operand/result width; must be ≥ 13 and even.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  operation request; sampled only when BUSY=0.
- A  in  SIZE  operand A (PC for AUIPC).
- B  in  SIZE  operand B (immediate for LUI/AUIPC).
- OPERATION  in  4  opcode; see Operation.
- BUSY  out  1  multi-cycle operation in progress; START is ignored.
- DONE  out  1  one-cycle pulse; RESULT/ZERO are new this cycle.
- RESULT  out  SIZE  registered result; holds until the next DONE.
- ZERO  out  1  registered, equal to (RESULT == 0).

## Operation
Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLT: signed A<B gives 1, else 0.
- 6 SLTU: unsigned A<B gives 1, else 0.
- 7 LUI: {B[SIZE-13:0],12'b0}.
- 8 AUIPC: A + {B[SIZE-13:0],12'b0}.
- 9 MUL: low SIZE bits of A×B.
- 10 MULH: high SIZE bits, signed×signed.
- 11 MULHU: high SIZE bits, unsigned×unsigned.
- 12 DIV, 13 DIVU, 14 REM, 15 REMU: quotient truncates toward zero; the remainder takes the dividend's sign.

FSM states IDLE, RUN, FIN:
- IDLE, START=1, opcode 0–8: compute, register RESULT/ZERO, pulse DONE next cycle, stay IDLE.
- IDLE, START=1, opcode 9–15: latch operand magnitudes and the result-sign flag, load counter=SIZE-1, go RUN. BUSY=1.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. When counter=0, go FIN.
- FIN: apply sign correction, register RESULT/ZERO, pulse DONE, go IDLE, BUSY=0.
- Arithmetic wraps modulo 2^SIZE. The multiply accumulator is 2·SIZE bits. Divide uses a SIZE+1-bit partial remainder.

Boundary cases:
- Divide by zero: DIV/DIVU give all-ones; REM/REMU give A. No exception is raised.
- Signed overflow (A = −2^(SIZE−1), B = −1): DIV gives A; REM gives 0.
- Special cases still take the full multi-cycle latency, so latency is data-independent.
- START while BUSY=1: ignored, not queued. OPERATION, A and B may change freely during RUN.
- Reset mid-operation: the operation is aborted, the FSM returns to IDLE and no DONE is produced.

## Timing
- Reset values: RESULT=0, ZERO=1, BUSY=0, DONE=0, FSM=IDLE, counter=0.
- Single-cycle ops: START sampled at edge E gives DONE=1 in the cycle after E. Back-to-back START every cycle produces DONE every cycle.
- Multi-cycle ops: START sampled at edge E makes BUSY rise after E. DONE is high in cycle E+SIZE+1, and BUSY falls in that same cycle. A new START is accepted in the DONE cycle.
- DONE never asserts with BUSY=0 in the preceding cycle for multi-cycle ops, except in the FIN cycle.

## Configuration
- ALU_MULDIV_EN defined: opcodes 9–15 behave as above.
- ALU_MULDIV_EN undefined:
  - No RUN/FIN datapath is synthesised and BUSY is tied 0.
  - Opcodes 9–15 complete in one cycle with RESULT=0, ZERO=1, DONE=1.

## Test plan
All values are for SIZE=32.
1. Reset with RST_N=0 for 2 cycles, START=1 held, A=5: RESULT=0, ZERO=1, BUSY=0, DONE=0 throughout.
2. SUB with A=7, B=7: DONE next cycle, RESULT=0, ZERO=1. SLT with A=0xFFFFFFFF, B=1 gives 1; SLTU with the same operands gives 0.
3. MULH with A=0x80000000, B=2 gives 0xFFFFFFFF. MUL with A=0xFFFFFFFF, B=0xFFFFFFFF gives 1. In both cases BUSY is high for cycles E+1..E+32 and DONE is high at E+33.
4. DIV with A=-7, B=2 gives 0xFFFFFFFD; REM with the same operands gives 0xFFFFFFFF. DIVU with B=0 gives 0xFFFFFFFF; REMU with A=9, B=0 gives 9. DIV with A=0x80000000, B=0xFFFFFFFF gives 0x80000000.
5. Issue START during RUN with a different opcode: the second START is ignored and only one DONE appears. Assert RST_N=0 at cycle E+10 of a DIV: no DONE, and BUSY=0 the cycle after.
6. Build with ALU_MULDIV_EN undefined: MUL with A=3, B=4 gives DONE next cycle, RESULT=0, and BUSY is never asserted.
